// File: rtl/a_fu_sched.sv
// Issue and write-back scheduler for the A-register add (030/031) and multiply (032) units.
// The single A write port is reserved at issue time via a shift register of write-back slots.
module a_fu_sched #(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_issue_valid,
  input  logic [6:0] i_instr,
  input  logic [2:0] i_ai,
  input  logic [2:0] i_aj,
  input  logic [2:0] i_ak,
  output logic       o_issue_ready,
  output logic       o_add_go,
  output logic       o_mul_go,
  output logic [7:0] o_a_busy,
  output logic       o_wb_valid,
  output logic [2:0] o_wb_addr,
  output logic       o_wb_sel
);

  // Slot k is written back k cycles after the current one; slot 0 drives the write port.
  logic [MUL_LAT-1:0] slot_valid_q, slot_valid_d;
  logic [MUL_LAT-1:0] slot_sel_q,   slot_sel_d;
  logic [2:0]         slot_addr_q [MUL_LAT];
  logic [2:0]         slot_addr_d [MUL_LAT];
  logic [7:0]         busy_q, busy_d;

  logic is_add;
  logic is_mul;
  logic regs_free;
  logic add_slot_free;
  logic accept_add;
  logic accept_mul;

  assign is_add = (i_instr == 7'o030) || (i_instr == 7'o031);
  assign is_mul = (i_instr == 7'o032);

  assign regs_free = !busy_q[i_ai] && !busy_q[i_aj] && !busy_q[i_ak];

  // An add lands ADD_LAT cycles out; only an earlier multiply can already own that slot.
  // A multiply targets the farthest slot, which nothing else ever loads.
  assign add_slot_free = !slot_valid_q[ADD_LAT];

  always_comb begin
    o_issue_ready = 1'b0;
    if (!rst) begin
      if (is_add) begin
        o_issue_ready = regs_free && add_slot_free;
      end else if (is_mul) begin
        o_issue_ready = regs_free;
      end else begin
        o_issue_ready = 1'b1;
      end
    end
  end

  assign accept_add = i_issue_valid && o_issue_ready && is_add;
  assign accept_mul = i_issue_valid && o_issue_ready && is_mul;
  assign o_add_go   = accept_add;
  assign o_mul_go   = accept_mul;

  genvar gi;
  generate
    for (gi = 0; gi < MUL_LAT; gi++) begin : g_slot
      if (gi == MUL_LAT - 1) begin : g_top
        assign slot_valid_d[gi] = accept_mul;
        assign slot_sel_d[gi]   = accept_mul;
        assign slot_addr_d[gi]  = accept_mul ? i_ai : 3'd0;
      end else if (gi == ADD_LAT - 1) begin : g_add_entry
        assign slot_valid_d[gi] = accept_add ? 1'b1 : slot_valid_q[gi+1];
        assign slot_sel_d[gi]   = accept_add ? 1'b0 : slot_sel_q[gi+1];
        assign slot_addr_d[gi]  = accept_add ? i_ai : slot_addr_q[gi+1];
      end else begin : g_shift
        assign slot_valid_d[gi] = slot_valid_q[gi+1];
        assign slot_sel_d[gi]   = slot_sel_q[gi+1];
        assign slot_addr_d[gi]  = slot_addr_q[gi+1];
      end
    end
  endgenerate

  // A write-back and a new reservation never target the same register,
  // because the destination of an accepted issue must not be busy.
  always_comb begin
    busy_d = busy_q;
    if (slot_valid_q[0]) begin
      busy_d[slot_addr_q[0]] = 1'b0;
    end
    if (accept_add || accept_mul) begin
      busy_d[i_ai] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= '0;
      slot_sel_q   <= '0;
      busy_q       <= 8'h00;
      for (int k = 0; k < MUL_LAT; k++) begin
        slot_addr_q[k] <= 3'd0;
      end
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_sel_q   <= slot_sel_d;
      busy_q       <= busy_d;
      for (int k = 0; k < MUL_LAT; k++) begin
        slot_addr_q[k] <= slot_addr_d[k];
      end
    end
  end

  assign o_a_busy   = busy_q;
  assign o_wb_valid = slot_valid_q[0];
  assign o_wb_addr  = slot_addr_q[0];
  assign o_wb_sel   = slot_sel_q[0];

endmodule

// File: doc/a_fu_sched.md
# a_fu_sched

Issue and write-back scheduler for the A-register functional units (address add, instructions 030/031; address multiply, 032). Sits between instruction issue and the address add/multiply datapaths. Checks A-register reservations, reserves the single A-register write port in advance, and emits the write-back strobe and destination when each result arrives. Because the write port is reserved at issue, two results never collide and no result buffering is needed.

## Interface
- ADD_LAT, 2: cycles from accepted issue to address add result valid; legal range 1..14.
- MUL_LAT, 6: cycles from accepted issue to address multiply result valid; must satisfy ADD_LAT < MUL_LAT ≤ 15.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_issue_valid  in  1  instruction presented this cycle.
- i_instr  in  7  opcode field; 7'o030, 7'o031, 7'o032 recognised.
- i_ai  in  3  destination A-register index.
- i_aj  in  3  first operand A-register index.
- i_ak  in  3  second operand A-register index.
- o_issue_ready  out  1  combinational; issue accepted this cycle when high with i_issue_valid.
- o_add_go  out  1  combinational pulse; accepted 030/031, datapath latches operands.
- o_mul_go  out  1  combinational pulse; accepted 032.
- o_a_busy  out  8  registered; bit n set = An has a pending result.
- o_wb_valid  out  1  registered; A-register write this cycle.
- o_wb_addr  out  3  registered; destination index for the write.
- o_wb_sel  out  1  registered; 0 = add result, 1 = multiply result.

## Operation
- Decode: 030/031 are class ADD with latency L=ADD_LAT. 032 is class MUL with L=MUL_LAT. Any other opcode is unrecognised: o_issue_ready=1, no go pulse, no state change.
- Accept conditions, all required: recognised opcode; o_a_busy[i_ai]=0, o_a_busy[i_aj]=0, o_a_busy[i_ak]=0; write-back slot t+L free.
- Index 0 is checked like any other index.
- Slot tracking: shift register of MUL_LAT entries, each holding valid/addr/sel. It shifts one position per cycle toward the output. Accepting an issue loads the entry L positions ahead. The output entry drives o_wb_*.
- Reservation: o_a_busy[i_ai] sets at the edge ending the accept cycle. It clears at the edge ending the cycle in which o_wb_valid=1 for that index.
- During the write-back cycle the bit is still set, so an issue reading or writing that register is blocked. It may issue in the following cycle.
- A destination can have only one pending result, so o_wb_addr is never duplicated in flight.
- Simultaneous write-back and new accept to a different register: both updates apply at the same edge.
- Reset: clears every slot and o_a_busy. Next cycle o_wb_valid=0, o_wb_addr=0, o_wb_sel=0, o_a_busy=8'h00. In-flight results are discarded.
- o_issue_ready, o_add_go and o_mul_go are gated by rst=0.

## Timing
- An issue accepted in cycle t produces o_wb_valid=1 in cycle t+L. The result is on the datapath output in the same cycle.
- An ADD issue at t is blocked if a MUL was accepted at t+ADD_LAT−MUL_LAT. With defaults, that means a MUL accepted 4 cycles earlier.
- Back-to-back same-class issues to distinct registers are accepted every cycle.
- o_issue_ready has a combinational path from i_instr, i_ai, i_aj, i_ak to the output.
- o_wb_* and o_a_busy change only at clock edges.

## Test plan
- Reset, then 030 with ai=3, aj=1, ak=2 at cycle 0:
  - o_add_go=1 in cycle 0;
  - o_a_busy=8'h08 in cycles 1–2;
  - o_wb_valid=1, addr=3, sel=0 in cycle 2;
  - o_a_busy=8'h00 in cycle 3.
- 032 with ai=5 at cycle 0, then 030 with ai=6 at cycle 4:
  - cycle 4 is blocked, o_issue_ready=0 (slot 6 is taken);
  - the same 030 is accepted at cycle 5, and write-backs land at cycles 6 (addr 5, sel 1) and 7 (addr 6).
- 031 with ai=4 at cycle 0, then 030 with aj=4:
  - the second instruction is blocked in cycles 1–2 and accepted in cycle 3.
- 030 with ai=1, 2, 3 at cycles 0, 1, 2:
  - all are accepted;
  - o_wb_valid=1 in cycles 2, 3, 4 with addr 1, 2, 3.
- Opcode 7'o040 with i_issue_valid=1:
  - o_issue_ready=1, no go pulse, no change to o_a_busy.
- 032 with ai=7 at cycle 0, rst=1 at cycle 3:
  - from cycle 4, o_a_busy=0;
  - no write-back in cycle 6.
